// File: rtl/usb_line_rx.sv
// usb_line_rx: passive USB receiver for the shared linep/linem bus.
// Synchronises the line, recovers bit timing from transitions, NRZI-decodes,
// hunts for SYNC, strips stuffed bits, assembles bytes and flags EOP/errors.
// Never drives the line. Also reports a long-SE0 bus reset condition.
module usb_line_rx #(
    parameter int FULLSPEED    = 1,
    parameter int CLKS_PER_BIT = 4,
    parameter int RESET_CLKS   = 120
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       linep,
    input  logic       linem,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_sop,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_err,
    output logic       bus_reset
);

    // Line states as {linem, linep}
    localparam logic [1:0] LS_J   = (FULLSPEED != 0) ? 2'b01 : 2'b10;
    localparam logic [1:0] LS_K   = (FULLSPEED != 0) ? 2'b10 : 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam int             PHW    = $clog2(CLKS_PER_BIT);
    localparam logic [PHW-1:0] PH_MAX = PHW'(CLKS_PER_BIT - 1);
    localparam logic [PHW-1:0] PH_SMP = PHW'(CLKS_PER_BIT / 2 - 1);
    localparam int             RCW    = $clog2(RESET_CLKS + 1);
    localparam logic [RCW-1:0] RC_MAX = RCW'(RESET_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ERR
    } state_t;

    state_t         state;
    logic [1:0]     sync1;
    logic [1:0]     ls_prev;
    logic [PHW-1:0] ph;
    logic [RCW-1:0] se0_cnt;
    logic [1:0]     prev_jk;
    logic [1:0]     zcnt;
    logic [2:0]     bcnt;
    logic [2:0]     ones;
    logic [7:0]     shreg;
    logic           misal;
    logic           err_seen;

    logic       ls_chg;
    logic       smp;
    logic       is_j;
    logic       is_k;
    logic       is_se0;
    logic       is_se1;
    logic       bit_dec;
    logic [7:0] shnext;

    assign ls_chg  = (line_state != ls_prev);
    // Never sample in the cycle a transition shows up: the counter is being
    // reloaded there, so the old phase value must not trigger a sample.
    assign smp     = (ph == PH_SMP) && !ls_chg;
    assign is_j    = (line_state == LS_J);
    assign is_k    = (line_state == LS_K);
    assign is_se0  = (line_state == LS_SE0);
    assign is_se1  = (line_state == LS_SE1);
    // NRZI: no change from the previous J/K sample is a 1
    assign bit_dec = (line_state == prev_jk);
    assign shnext  = {bit_dec, shreg[7:1]};

    assign bus_reset = is_se0 && (se0_cnt >= RC_MAX);

    // Two-flop synchroniser plus one-cycle history for transition detection
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1      <= 2'b00;
            line_state <= 2'b00;
            ls_prev    <= 2'b00;
        end else begin
            sync1      <= {linem, linep};
            line_state <= sync1;
            ls_prev    <= line_state;
        end
    end

    // Bit phase counter, re-aligned on every line transition
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ph <= '0;
        end else if (ls_chg || ph == PH_MAX) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    // Saturating SE0 duration counter for bus reset detection
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            se0_cnt <= '0;
        end else if (!is_se0) begin
            se0_cnt <= '0;
        end else if (se0_cnt != RC_MAX) begin
            se0_cnt <= se0_cnt + 1'b1;
        end
    end

    // Receive state machine with registered strobes
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_IDLE;
            prev_jk   <= LS_J;
            zcnt      <= '0;
            bcnt      <= '0;
            ones      <= '0;
            shreg     <= '0;
            misal     <= 1'b0;
            err_seen  <= 1'b0;
            rx_active <= 1'b0;
            rx_sop    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_eop    <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_sop   <= 1'b0;
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
            if (smp && (is_j || is_k)) prev_jk <= line_state;

            case (state)
                S_IDLE: begin
                    prev_jk <= LS_J;
                    if (smp && is_k) begin
                        // first K after idle J is the first 0 of SYNC
                        state   <= S_SYNC;
                        zcnt    <= 2'd1;
                        prev_jk <= LS_K;
                    end
                end

                S_SYNC: begin
                    if (smp) begin
                        if (is_se0 || is_se1) begin
                            state <= S_IDLE;
                        end else if (!bit_dec) begin
                            if (zcnt != 2'd3) zcnt <= zcnt + 2'd1;
                        end else if (zcnt == 2'd3) begin
                            state     <= S_DATA;
                            rx_sop    <= 1'b1;
                            rx_active <= 1'b1;
                            bcnt      <= '0;
                            ones      <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (smp) begin
                        if (is_se0) begin
                            state <= S_EOP;
                            misal <= (bcnt != 3'd0);
                        end else if (is_se1) begin
                            rx_err    <= 1'b1;
                            rx_active <= 1'b0;
                            err_seen  <= 1'b0;
                            state     <= S_ERR;
                        end else if (ones == 3'd6) begin
                            // stuffed position: must be a 0, never counted
                            if (bit_dec) begin
                                rx_err    <= 1'b1;
                                rx_active <= 1'b0;
                                err_seen  <= 1'b0;
                                state     <= S_ERR;
                            end else begin
                                ones <= '0;
                            end
                        end else begin
                            shreg <= shnext;
                            ones  <= bit_dec ? ones + 3'd1 : 3'd0;
                            if (bcnt == 3'd7) begin
                                rx_data  <= shnext;
                                rx_valid <= 1'b1;
                                bcnt     <= '0;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end
                    end else if (bus_reset) begin
                        // long SE0 ends the packet like a normal EOP
                        state <= S_EOP;
                        misal <= (bcnt != 3'd0);
                    end
                end

                S_EOP: begin
                    if (smp && is_j) begin
                        rx_eop    <= 1'b1;
                        rx_err    <= misal;
                        rx_active <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_ERR: begin
                    // leave only after a J that follows an SE0 or J sample
                    if (smp && (is_j || is_se0)) begin
                        if (is_j && err_seen) state <= S_IDLE;
                        err_seen <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
